// File: rtl/fpmul_result_sink_if.sv
// Result-side bus of fpmul_result_sink: FPmul output capture plus the FIFO read port.
// The master modport is the producer/reader side; the slave modport is the sink.
interface fpmul_result_sink_if;
  logic        VIN;
  logic [31:0] DIN;
  logic        RD_EN;
  logic [31:0] DOUT;
  logic        DOUT_V;
  logic        EMPTY;
  logic        FULL;

  modport master (
    output VIN,
    output DIN,
    output RD_EN,
    input  DOUT,
    input  DOUT_V,
    input  EMPTY,
    input  FULL
  );

  modport slave (
    input  VIN,
    input  DIN,
    input  RD_EN,
    output DOUT,
    output DOUT_V,
    output EMPTY,
    output FULL
  );
endinterface

// File: rtl/fpmul_result_sink.sv
// Sink for FPmul results: realigns operand validity to FP_Z, classifies and signs each
// captured word, and buffers it in a FIFO for readout.
module fpmul_result_sink #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST_n,
  fpmul_result_sink_if.slave bus,
  output logic               OVF,
  output logic [CNT_W-1:0]   SAMPLE_CNT,
  output logic [CNT_W-1:0]   NAN_CNT,
  output logic [CNT_W-1:0]   INF_CNT,
  output logic [CNT_W-1:0]   ZERO_CNT,
  output logic [CNT_W-1:0]   DEN_CNT,
  output logic [31:0]        SIG
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] sig_fold(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31]} ^ d;
  endfunction

  // ---- validity delay line: stage i holds VIN from i+1 edges ago ----
  logic [LATENCY-1:0] vld_p;
  logic               cap;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= bus.VIN;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  assign cap = vld_p[LATENCY-1];

  // ---- capture edge: IEEE-754 single classification of DIN (sign ignored) ----
  logic [7:0] din_e;
  logic       din_m_nz;
  logic       e_ones;
  logic       e_zero;
  logic       is_nan;
  logic       is_inf;
  logic       is_zero;
  logic       is_den;

  assign din_e    = bus.DIN[30:23];
  assign din_m_nz = |bus.DIN[22:0];
  assign e_ones   = &din_e;
  assign e_zero   = ~|din_e;
  assign is_nan   = e_ones & din_m_nz;
  assign is_inf   = e_ones & ~din_m_nz;
  assign is_zero  = e_zero & ~din_m_nz;
  assign is_den   = e_zero & din_m_nz;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      SAMPLE_CNT <= '0;
      NAN_CNT    <= '0;
      INF_CNT    <= '0;
      ZERO_CNT   <= '0;
      DEN_CNT    <= '0;
      SIG        <= '0;
    end else if (cap) begin
      SAMPLE_CNT <= sat_inc(SAMPLE_CNT);
      if (is_nan)  NAN_CNT  <= sat_inc(NAN_CNT);
      if (is_inf)  INF_CNT  <= sat_inc(INF_CNT);
      if (is_zero) ZERO_CNT <= sat_inc(ZERO_CNT);
      if (is_den)  DEN_CNT  <= sat_inc(DEN_CNT);
      SIG <= sig_fold(SIG, bus.DIN);
    end
  end

  // ---- capture FIFO ----
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          empty_s;
  logic          full_s;
  logic          pop;
  logic          push;
  logic [31:0]   dout_r;
  logic          dout_v_r;

  assign empty_s = (occ == '0);
  assign full_s  = (occ == OCC_FULL);
  assign pop     = bus.RD_EN & ~empty_s;
  // A pop on the same edge frees the slot a full FIFO needs for the incoming word.
  assign push    = cap & (~full_s | pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.DIN;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      OVF      <= 1'b0;
      dout_r   <= '0;
      dout_v_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (cap && !push) OVF <= 1'b1;
      dout_v_r <= pop;
      if (pop) dout_r <= mem[rd_ptr];
    end
  end

  assign bus.DOUT   = dout_r;
  assign bus.DOUT_V = dout_v_r;
  assign bus.EMPTY  = empty_s;
  assign bus.FULL   = full_s;

  a_occ_bound: assert property (@(posedge CLK) disable iff (!RST_n) occ <= OCC_FULL);
  a_flags_excl: assert property (@(posedge CLK) disable iff (!RST_n) !(empty_s && full_s));
endmodule

// File: tb/tb_fpmul_result_sink.sv
// Bench for fpmul_result_sink: hand sequences, a classification table, and random
// traffic against a queue-based reference model (plus a narrow-counter instance).
module tb_fpmul_result_sink;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 3;
  localparam int SAT_MAX = (1 << SAT_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  // cls: 0 NaN, 1 Inf, 2 zero, 3 denormal, 4 normal
  typedef struct {
    logic [31:0] din;
    int          cls;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpmul_result_sink_if bus ();
  fpmul_result_sink_if bus_s ();
  assign bus_s.VIN   = bus.VIN;
  assign bus_s.DIN   = bus.DIN;
  assign bus_s.RD_EN = bus.RD_EN;

  logic             ovf, ovf_s;
  logic [CNT_W-1:0] sample_cnt, nan_cnt, inf_cnt, zero_cnt, den_cnt;
  logic [SAT_W-1:0] sample_s, nan_s, inf_s, zero_s, den_s;
  logic [31:0]      sig, sig_s;

  fpmul_result_sink #(.LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST_n(rst_n), .bus(bus), .OVF(ovf), .SAMPLE_CNT(sample_cnt),
    .NAN_CNT(nan_cnt), .INF_CNT(inf_cnt), .ZERO_CNT(zero_cnt), .DEN_CNT(den_cnt), .SIG(sig)
  );

  fpmul_result_sink #(.LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(SAT_W)) dut_s (
    .CLK(clk), .RST_n(rst_n), .bus(bus_s), .OVF(ovf_s), .SAMPLE_CNT(sample_s),
    .NAN_CNT(nan_s), .INF_CNT(inf_s), .ZERO_CNT(zero_s), .DEN_CNT(den_s), .SIG(sig_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          cyc = 0;
  bit          cap_at [int];
  logic [31:0] din_at [int];
  logic [31:0] mq [$];
  int          m_sample, m_cls [5];
  bit          m_ovf, m_doutv;
  logic [31:0] m_sig, m_dout;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int cls_of(input logic [31:0] d);
    if (d[30:23] == 8'hFF) return (d[22:0] != 0) ? 0 : 1;
    if (d[30:23] == 8'h00) return (d[22:0] == 0) ? 2 : 3;
    return 4;
  endfunction

  function automatic int sat_lim(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    cap_at.delete();
    mq.delete();
    m_sample = 0;
    for (int i = 0; i < 5; i++) m_cls[i] = 0;
    m_ovf = 1'b0; m_doutv = 1'b0; m_sig = '0; m_dout = '0;
  endtask

  // One clock edge: drive inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic step(input bit vin, input bit rd);
    logic [31:0] d;
    int c;
    d = din_at.exists(cyc) ? din_at[cyc] : JUNK;
    bus.VIN = vin; bus.DIN = d; bus.RD_EN = rd;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_doutv = 1'b0;
      if (rd && mq.size() > 0) begin
        m_dout  = mq.pop_front();
        m_doutv = 1'b1;
      end
      if (cap_at.exists(cyc)) begin
        m_sample = (m_sample < CNT_MAX) ? m_sample + 1 : m_sample;
        c = cls_of(d);
        m_cls[c]++;
        m_sig = {m_sig[30:0], m_sig[31]} ^ d;
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
        cap_at.delete(cyc);
      end
      if (vin) cap_at[cyc + LATENCY] = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.VIN = 1'b0; bus.RD_EN = 1'b0;
  endtask

  task automatic issue(input logic [31:0] w, input bit rd);
    din_at[cyc + LATENCY] = w;
    step(1'b1, rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic compare_all();
    check("dout", bus.DOUT, m_dout);
    check("dout_v", 32'(bus.DOUT_V), 32'(m_doutv));
    check("empty", 32'(bus.EMPTY), 32'(mq.size() == 0));
    check("full", 32'(bus.FULL), 32'(mq.size() == DEPTH));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("sample", 32'(sample_cnt), 32'(m_sample));
    check("nan", 32'(nan_cnt), 32'(m_cls[0]));
    check("inf", 32'(inf_cnt), 32'(m_cls[1]));
    check("zero", 32'(zero_cnt), 32'(m_cls[2]));
    check("den", 32'(den_cnt), 32'(m_cls[3]));
    check("sig", sig, m_sig);
    check("s_dout", bus_s.DOUT, m_dout);
    check("s_flags", {29'd0, bus_s.DOUT_V, bus_s.EMPTY, bus_s.FULL},
          {29'd0, m_doutv, mq.size() == 0, mq.size() == DEPTH});
    check("s_ovf", 32'(ovf_s), 32'(m_ovf));
    check("s_sample", 32'(sample_s), 32'(sat_lim(m_sample, SAT_MAX)));
    check("s_nan", 32'(nan_s), 32'(sat_lim(m_cls[0], SAT_MAX)));
    check("s_inf", 32'(inf_s), 32'(sat_lim(m_cls[1], SAT_MAX)));
    check("s_zero", 32'(zero_s), 32'(sat_lim(m_cls[2], SAT_MAX)));
    check("s_den", 32'(den_s), 32'(sat_lim(m_cls[3], SAT_MAX)));
    check("s_sig", sig_s, m_sig);
  endtask

  function automatic logic [31:0] rand_word();
    logic       s;
    logic [7:0] e;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 31'd0};
      3: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      4: begin
        e = 8'($urandom_range(1, 254));
        return {s, e, 23'($urandom)};
      end
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl [12];
  logic [31:0] w [10];
  int          exp_cls [5];
  int          exp_total;

  initial begin
    tbl[0]  = '{32'h7FC00000, 0};
    tbl[1]  = '{32'hFFFFFFFF, 0};
    tbl[2]  = '{32'h7F800001, 0};
    tbl[3]  = '{32'h7F800000, 1};
    tbl[4]  = '{32'hFF800000, 1};
    tbl[5]  = '{32'h00000000, 2};
    tbl[6]  = '{32'h80000000, 2};
    tbl[7]  = '{32'h00000001, 3};
    tbl[8]  = '{32'h807FFFFF, 3};
    tbl[9]  = '{32'h00800000, 4};
    tbl[10] = '{32'h7F7FFFFF, 4};
    tbl[11] = '{32'h3F800000, 4};
    for (int i = 0; i < 10; i++) w[i] = 32'h41000000 + 32'(i);

    bus.VIN = 1'b0; bus.DIN = JUNK; bus.RD_EN = 1'b0;
    #2;
    model_reset();

    // Reset state
    do_reset();
    check("rst_dout", bus.DOUT, 32'h0);
    check("rst_dout_v", 32'(bus.DOUT_V), 32'd0);
    check("rst_empty", 32'(bus.EMPTY), 32'd1);
    check("rst_full", 32'(bus.FULL), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_sample", 32'(sample_cnt), 32'd0);
    check("rst_sig", sig, 32'h0);

    // Latency alignment: only the word present on the capture edge is taken
    repeat (6) step(1'b0, 1'b0);
    issue(32'h40400000, 1'b0);
    repeat (LATENCY - 1) step(1'b0, 1'b0);
    check("lat_early", 32'(sample_cnt), 32'd0);
    step(1'b0, 1'b0);
    check("lat_sample", 32'(sample_cnt), 32'd1);
    check("lat_cls", 32'(nan_cnt) + 32'(inf_cnt) + 32'(zero_cnt) + 32'(den_cnt), 32'd0);
    step(1'b0, 1'b1);
    check("lat_dout", bus.DOUT, 32'h40400000);
    check("lat_dout_v", 32'(bus.DOUT_V), 32'd1);
    check("lat_empty", 32'(bus.EMPTY), 32'd1);

    // Classification burst
    do_reset();
    issue(32'h7FC00000, 1'b0);
    issue(32'h7F800000, 1'b0);
    issue(32'h80000000, 1'b0);
    issue(32'h00000001, 1'b0);
    issue(32'h3F800000, 1'b0);
    repeat (LATENCY) step(1'b0, 1'b0);
    check("cls_nan", 32'(nan_cnt), 32'd1);
    check("cls_inf", 32'(inf_cnt), 32'd1);
    check("cls_zero", 32'(zero_cnt), 32'd1);
    check("cls_den", 32'(den_cnt), 32'd1);
    check("cls_sample", 32'(sample_cnt), 32'd5);

    // Classification table, one capture and one pop per entry
    do_reset();
    for (int i = 0; i < 5; i++) exp_cls[i] = 0;
    exp_total = 0;
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].din, 1'b0);
      repeat (LATENCY) step(1'b0, 1'b0);
      exp_cls[tbl[i].cls]++;
      exp_total++;
      check("tbl_nan", 32'(nan_cnt), 32'(exp_cls[0]));
      check("tbl_inf", 32'(inf_cnt), 32'(exp_cls[1]));
      check("tbl_zero", 32'(zero_cnt), 32'(exp_cls[2]));
      check("tbl_den", 32'(den_cnt), 32'(exp_cls[3]));
      check("tbl_sample", 32'(sample_cnt), 32'(exp_total));
      step(1'b0, 1'b1);
      check("tbl_dout", bus.DOUT, tbl[i].din);
    end

    // Signature
    do_reset();
    issue(32'h00000001, 1'b0);
    issue(32'h00000002, 1'b0);
    repeat (LATENCY - 1) step(1'b0, 1'b0);
    check("sig_first", sig, 32'h00000001);
    step(1'b0, 1'b0);
    check("sig_second", sig, 32'h00000000);

    // Overflow, then drain in order
    do_reset();
    for (int i = 0; i < 9; i++) issue(w[i], 1'b0);
    repeat (LATENCY - 1) step(1'b0, 1'b0);
    check("ovf_full8", 32'(bus.FULL), 32'd1);
    check("ovf_pre", 32'(ovf), 32'd0);
    step(1'b0, 1'b0);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_sample", 32'(sample_cnt), 32'd9);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      check("ovf_pop", bus.DOUT, w[i]);
      check("ovf_pop_v", 32'(bus.DOUT_V), 32'd1);
    end
    check("ovf_empty", 32'(bus.EMPTY), 32'd1);
    step(1'b0, 1'b1);
    check("ovf_rd_empty_v", 32'(bus.DOUT_V), 32'd0);
    check("ovf_rd_empty_hold", bus.DOUT, w[7]);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 8; i++) issue(w[i], 1'b0);
    repeat (LATENCY) step(1'b0, 1'b0);
    check("fpp_full", 32'(bus.FULL), 32'd1);
    issue(32'h42000000, 1'b0);
    repeat (LATENCY - 1) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("fpp_dout", bus.DOUT, w[0]);
    check("fpp_dout_v", 32'(bus.DOUT_V), 32'd1);
    check("fpp_full_kept", 32'(bus.FULL), 32'd1);
    check("fpp_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b1);
      check("fpp_drain", bus.DOUT, w[i]);
    end
    step(1'b0, 1'b1);
    check("fpp_new", bus.DOUT, 32'h42000000);
    check("fpp_empty", 32'(bus.EMPTY), 32'd1);

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 10; i++) issue(32'h00000000, 1'b0);
    repeat (LATENCY) step(1'b0, 1'b0);
    check("sat_zero_narrow", 32'(zero_s), 32'(SAT_MAX));
    check("sat_sample_narrow", 32'(sample_s), 32'(SAT_MAX));
    check("sat_zero_wide", 32'(zero_cnt), 32'd10);
    check("sat_sig_equal", sig_s, sig);

    // Reset while results are in flight
    do_reset();
    issue(w[0], 1'b0);
    issue(w[1], 1'b0);
    issue(w[2], 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (LATENCY + 2) step(1'b0, 1'b0);
    check("mid_sample", 32'(sample_cnt), 32'd0);
    check("mid_empty", 32'(bus.EMPTY), 32'd1);
    check("mid_sig", sig, 32'h0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit vin, rd;
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        step(1'b0, 1'b1);
        rst_n = 1'b1;
      end else begin
        vin = ($urandom_range(0, 1) == 1);
        rd  = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
        if (vin) din_at[cyc + LATENCY] = rand_word();
        step(vin, rd);
      end
      compare_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
